ours_xm_to_jtag_tap_shifter: RTL and testbench

//  Bit-level JTAG TAP driver below the xm-to-jtag request processor. Takes one
//  {inst, data, size} shift command and walks the target TAP from Run-Test/Idle

---
 rtl/ours_xm_to_jtag_tap_shifter.sv | 222 ++++++++++++++++++++++
 tb/tb_ours_xm_to_jtag_tap_shifter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ours_xm_to_jtag_tap_shifter.sv
// Bit-level JTAG TAP driver: walks Run-Test/Idle -> IR scan -> DR scan -> Run-Test/Idle
// for one {inst, data, size} command and captures TDO of the DR scan into data_o.
module ours_xm_to_jtag_tap_shifter #(
    parameter int unsigned JTAG2OR_CODE_SIZE = 4,
    parameter int unsigned DATA_IN_W         = 128,
    parameter int unsigned DATA_OUT_W        = 64,
    parameter int unsigned TDO_DLY           = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vld_i,
    input  logic [JTAG2OR_CODE_SIZE-1:0] inst_i,
    input  logic [DATA_IN_W-1:0]         data_i,
    input  logic [7:0]                   data_size_i,
    output logic                         vld_o,
    output logic [DATA_OUT_W-1:0]        data_o,
    output logic                         busy_o,
    output logic                         jtag_tms_o,
    output logic                         jtag_tdi_o,
    input  logic                         jtag_tdo_i
);

    localparam int unsigned C_W   = JTAG2OR_CODE_SIZE;
    localparam int unsigned CNT_W = $clog2(DATA_IN_W) + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE_IR, ST_SH_IR, ST_MID, ST_SH_DR, ST_POST
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        size_q, size_d;
    logic [C_W-1:0]          inst_sr_q, inst_sr_d;
    logic [DATA_IN_W-1:0]    data_sr_q, data_sr_d;
    logic [DATA_OUT_W-1:0]   data_q, data_d;
    logic                    tms_q, tms_d;
    logic                    tdi_q, tdi_d;
    logic                    vld_q, vld_d;
    logic                    busy_q, busy_d;

    logic [CNT_W-1:0]        size_c;
    logic                    dr_bit_c;
    logic                    cap_en_c;
    logic [CNT_W-1:0]        cap_idx_c;

    // Zero-length scans become one bit; oversized requests clamp to the DR width.
    always_comb begin
        if (data_size_i == 8'd0) begin
            size_c = CNT_W'(1);
        end else if (32'(data_size_i) > DATA_IN_W) begin
            size_c = CNT_W'(DATA_IN_W);
        end else begin
            size_c = CNT_W'(data_size_i);
        end
    end

    assign dr_bit_c = (state_q == ST_SH_DR);

    generate
        if (TDO_DLY == 0) begin : g_no_dly
            assign cap_en_c  = dr_bit_c;
            assign cap_idx_c = cnt_q;
        end else begin : g_dly
            logic             en_q  [TDO_DLY];
            logic [CNT_W-1:0] idx_q [TDO_DLY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned k = 0; k < TDO_DLY; k++) begin
                        en_q[k]  <= 1'b0;
                        idx_q[k] <= '0;
                    end
                end else begin
                    en_q[0]  <= dr_bit_c;
                    idx_q[0] <= cnt_q;
                    for (int unsigned k = 1; k < TDO_DLY; k++) begin
                        en_q[k]  <= en_q[k-1];
                        idx_q[k] <= idx_q[k-1];
                    end
                end
            end

            assign cap_en_c  = en_q[TDO_DLY-1];
            assign cap_idx_c = idx_q[TDO_DLY-1];
        end
    endgenerate

    // Next state; TMS/TDI are derived from the state being entered so they leave a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        inst_sr_d = inst_sr_q;
        data_sr_d = data_sr_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        tms_d     = 1'b0;
        tdi_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vld_i) begin
                    state_d   = ST_PRE_IR;
                    cnt_d     = '0;
                    size_d    = size_c;
                    inst_sr_d = inst_i;
                    data_sr_d = data_i;
                    data_d    = '0;
                end
            end
            ST_PRE_IR: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = ST_SH_IR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SH_IR: begin
                if (cnt_q == CNT_W'(C_W - 1)) begin
                    state_d = ST_MID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MID: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = ST_SH_DR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SH_DR: begin
                if (cnt_q == size_q - CNT_W'(1)) begin
                    state_d = ST_POST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_POST: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            ST_PRE_IR: tms_d = (cnt_d < CNT_W'(2));
            ST_SH_IR: begin
                tms_d     = (cnt_d == CNT_W'(C_W - 1));
                tdi_d     = inst_sr_q[0];
                inst_sr_d = inst_sr_q >> 1;
            end
            ST_MID:    tms_d = (cnt_d < CNT_W'(2));
            ST_SH_DR: begin
                tms_d     = (cnt_d == size_q - CNT_W'(1));
                tdi_d     = data_sr_q[0];
                data_sr_d = data_sr_q >> 1;
            end
            ST_POST:   tms_d = (cnt_d == CNT_W'(0));
            default: begin
                tms_d = 1'b0;
                tdi_d = 1'b0;
            end
        endcase

        // Delayed DR bit index selects its capture slot; bits past DATA_OUT_W fall away.
        if (cap_en_c) begin
            for (int unsigned j = 0; j < DATA_OUT_W; j++) begin
                if (cap_idx_c == CNT_W'(j)) begin
                    data_d[j] = jtag_tdo_i;
                end
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            size_q    <= '0;
            inst_sr_q <= '0;
            data_sr_q <= '0;
            data_q    <= '0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            inst_sr_q <= inst_sr_d;
            data_sr_q <= data_sr_d;
            data_q    <= data_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
        end
    end

    assign vld_o      = vld_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign jtag_tms_o = tms_q;
    assign jtag_tdi_o = tdi_q;

endmodule

// File: tb/tb_ours_xm_to_jtag_tap_shifter.sv
// Directed bench for the TAP shifter: three instances (TDO_DLY 0/1/2) share stimulus,
// each fed by a target model that returns a per-command TDO pattern on its DR bits.
module tb_ours_xm_to_jtag_tap_shifter;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_i;
    logic [3:0]  inst_i;
    logic [127:0] data_i;
    logic [7:0]  data_size_i;
    logic        vld_o  [3];
    logic [63:0] data_o [3];
    logic        busy_o [3];
    logic        tms_o  [3];
    logic        tdi_o  [3];
    logic        tdo    [3];

    int          cyc = 0;
    int          n_acc = -1000;
    int          s_cur = 0;
    logic [127:0] tdo_pat = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Target model: DR bit i (first on TDI in cycle N+9+C+i) returns pattern bit i
    // D cycles later; any other cycle returns 1 so stray captures show up.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            if ((cyc - n_acc - 9 - CW - d) >= 0 && (cyc - n_acc - 9 - CW - d) < s_cur)
                tdo[d] = tdo_pat[7'(cyc - n_acc - 9 - CW - d)];
            else
                tdo[d] = 1'b1;
        end
    end

    ours_xm_to_jtag_tap_shifter #(.TDO_DLY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .inst_i(inst_i), .data_i(data_i),
        .data_size_i(data_size_i), .vld_o(vld_o[0]), .data_o(data_o[0]), .busy_o(busy_o[0]),
        .jtag_tms_o(tms_o[0]), .jtag_tdi_o(tdi_o[0]), .jtag_tdo_i(tdo[0]));
    ours_xm_to_jtag_tap_shifter u_d1 (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .inst_i(inst_i), .data_i(data_i),
        .data_size_i(data_size_i), .vld_o(vld_o[1]), .data_o(data_o[1]), .busy_o(busy_o[1]),
        .jtag_tms_o(tms_o[1]), .jtag_tdi_o(tdi_o[1]), .jtag_tdo_i(tdo[1]));
    ours_xm_to_jtag_tap_shifter #(.TDO_DLY(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .inst_i(inst_i), .data_i(data_i),
        .data_size_i(data_size_i), .vld_o(vld_o[2]), .data_o(data_o[2]), .busy_o(busy_o[2]),
        .jtag_tms_o(tms_o[2]), .jtag_tdi_o(tdi_o[2]), .jtag_tdo_i(tdo[2]));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command at the current negedge (cycle N) and returns at the negedge of
    // the vld_o cycle. Per-cycle traces are bit k = cycle N+k.
    task automatic run_cmd(input string tag, input logic [3:0] inst, input logic [127:0] data,
                           input logic [7:0] sz, input int s_eff, input logic [127:0] pat,
                           input logic [63:0] exp_data, input int poke_k);
        logic [255:0] et, ed, eb, ev;
        logic [255:0] ot [3];
        logic [255:0] od [3];
        logic [255:0] ob [3];
        logic [255:0] ov [3];
        int L, k;
        L  = CW + s_eff + 11;
        et = '0; ed = '0; eb = '0; ev = '0;
        for (int d = 0; d < 3; d++) begin
            ot[d] = '0; od[d] = '0; ob[d] = '0; ov[d] = '0;
        end
        et[1] = 1'b1; et[2] = 1'b1;
        k = 5;
        for (int i = 0; i < CW; i++) begin
            ed[k] = inst[i]; et[k] = (i == CW - 1); k++;
        end
        et[k] = 1'b1; et[k+1] = 1'b1; k += 4;
        for (int i = 0; i < s_eff; i++) begin
            ed[k] = data[i]; et[k] = (i == s_eff - 1); k++;
        end
        et[k] = 1'b1;
        for (int j = 1; j < L; j++) eb[j] = 1'b1;
        ev[L] = 1'b1;

        inst_i = inst; data_i = data; data_size_i = sz; vld_i = 1'b1;
        tdo_pat = pat; s_cur = s_eff; n_acc = cyc;
        @(negedge clk);
        vld_i = 1'b0;
        for (k = 1; k <= L; k++) begin
            for (int d = 0; d < 3; d++) begin
                ot[d][k] = tms_o[d]; od[d][k] = tdi_o[d];
                ob[d][k] = busy_o[d]; ov[d][k] = vld_o[d];
            end
            if (k == poke_k) begin
                vld_i = 1'b1; inst_i = 4'hF; data_i = '1; data_size_i = 8'd1;
            end else if (k == poke_k + 1) begin
                vld_i = 1'b0;
            end
            if (k < L) @(negedge clk);
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.tms.d%0d", tag, d), ot[d], et);
            chk($sformatf("%s.tdi.d%0d", tag, d), od[d], ed);
            chk($sformatf("%s.busy.d%0d", tag, d), ob[d], eb);
            chk($sformatf("%s.vld.d%0d", tag, d), ov[d], ev);
            chk($sformatf("%s.data.d%0d", tag, d), {192'b0, data_o[d]}, {192'b0, exp_data});
        end
    endtask

    initial begin
        logic [255:0] seen;
        vld_i = 1'b0; inst_i = '0; data_i = '0; data_size_i = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.ctl.d%0d", d), {252'b0, tms_o[d], tdi_o[d], vld_o[d], busy_o[d]}, '0);
            chk($sformatf("rst.data.d%0d", d), {192'b0, data_o[d]}, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("basic", 4'b0010, 128'h1F, 8'd5, 5, 128'h0, 64'h0, 0);
        @(negedge clk);
        run_cmd("bit0", 4'b0111, 128'h16, 8'd5, 5, 128'h1, 64'h1, 0);
        @(negedge clk);
        run_cmd("s64", 4'b1010, 128'h0F0F_3C3C_9999_0000, 8'd64, 64,
                {64'h0, 64'hDEADBEEF_01234567}, 64'hDEADBEEF_01234567, 0);
        @(negedge clk);
        run_cmd("s128", 4'b0110, {64'hA5A5A5A5_A5A5A5A5, 64'h01234567_89ABCDEF}, 8'd128, 128,
                {64'h55555555_55555555, 64'h0F1E2D3C_4B5A6978}, 64'h0F1E2D3C_4B5A6978, 0);
        @(negedge clk);
        run_cmd("sz0", 4'b0011, 128'h1, 8'd0, 1, 128'h1, 64'h1, 0);
        @(negedge clk);
        run_cmd("sz200", 4'b1001, {1'b1, 126'h0, 1'b1}, 8'd200, 128,
                {64'hFFFF0000_FFFF0000, 64'h0000_0000_0000_1234}, 64'h1234, 0);
        repeat (2) @(negedge clk);
        run_cmd("poke", 4'b1100, 128'h0A, 8'd5, 5, 128'h15, 64'h15, 3);
        run_cmd("b2b", 4'b0001, 128'h3, 8'd2, 2, 128'h2, 64'h2, 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a scan at cycle N+10.
        inst_i = 4'b0101; data_i = 128'h1F; data_size_i = 8'd5; vld_i = 1'b1;
        tdo_pat = '1; s_cur = 5; n_acc = cyc;
        @(negedge clk);
        vld_i = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid.busy_before", {255'b0, busy_o[1]}, 256'h1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid.rst.d%0d", d),
                {188'b0, data_o[d], tms_o[d], tdi_o[d], vld_o[d], busy_o[d]}, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        repeat (30) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) seen[d] = seen[d] | vld_o[d] | busy_o[d];
        end
        chk("mid.quiet", seen, '0);
        n_acc = -1000;
        run_cmd("after_rst", 4'b1110, 128'h09, 8'd4, 4, 128'h6, 64'h6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
